// File: rtl/detonator_pkg.sv
// Shared constants for the detonator keypad path: key count, code width, named key indices.
package detonator_pkg;
    localparam int unsigned N_KEYS_DEF  = 12;
    localparam int unsigned CODE_W_DEF  = 4;
    localparam int unsigned KEY_CONFIRM = 10;
    localparam int unsigned KEY_CLEAR   = 11;
endpackage

// File: rtl/key_event_arbiter_if.sv
// Key-event bus between the debounce bank, the arbiter and the code-entry FSM.
interface key_event_arbiter_if #(
    parameter int unsigned N_KEYS = detonator_pkg::N_KEYS_DEF,
    parameter int unsigned CODE_W = detonator_pkg::CODE_W_DEF
);
    logic [N_KEYS-1:0] key_pulse;
    logic              lock;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        output key_pulse, lock, out_ready, overrun_clr,
        input  out_valid, out_code, busy, overrun
    );

    modport slave (
        input  key_pulse, lock, out_ready, overrun_clr,
        output out_valid, out_code, busy, overrun
    );
endinterface

// File: rtl/key_arb_pick.sv
// Combinational winner select over the pending vector.
// KEY_ARB_RR_EN: round-robin search from ptr; otherwise lowest index wins.
module key_arb_pick #(
    parameter int unsigned N_KEYS = detonator_pkg::N_KEYS_DEF,
    parameter int unsigned CODE_W = detonator_pkg::CODE_W_DEF
) (
    input  logic [N_KEYS-1:0] pending,
`ifdef KEY_ARB_RR_EN
    input  logic [CODE_W-1:0] ptr,
`endif
    output logic              any,
    output logic [CODE_W-1:0] winner
);

`ifdef KEY_ARB_RR_EN
    logic found;

    // Index of the k-th candidate counting up from p, wrapping at N_KEYS.
    function automatic logic [CODE_W-1:0] rr_idx(input logic [CODE_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= int'(N_KEYS)) s = s - int'(N_KEYS);
        return CODE_W'(s);
    endfunction

    always_comb begin
        any    = |pending;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(N_KEYS); k++) begin
            if (!found && pending[rr_idx(ptr, k)]) begin
                winner = rr_idx(ptr, k);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        any    = |pending;
        winner = '0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (pending[i]) winner = CODE_W'(i);
        end
    end
`endif

endmodule

// File: rtl/key_event_arbiter.sv
// Latches debounced key pulses as pending requests and hands one key code at a
// time to the code-entry FSM over valid/ready. KEY_ARB_RR_EN selects round-robin.
module key_event_arbiter
    import detonator_pkg::*;
#(
    parameter int unsigned N_KEYS = N_KEYS_DEF,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    key_event_arbiter_if.slave  bus
);

    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] pending_n;
    logic [N_KEYS-1:0] grant_vec;
    logic              out_valid_q;
    logic [CODE_W-1:0] out_code_q;
    logic              overrun_q;
    logic              any;
    logic              load;
    logic              ovr_ev;
    logic [CODE_W-1:0] winner;

`ifdef KEY_ARB_RR_EN
    logic [CODE_W-1:0] ptr;
`endif

    key_arb_pick #(
        .N_KEYS (N_KEYS),
        .CODE_W (CODE_W)
    ) u_pick (
        .pending (pending),
`ifdef KEY_ARB_RR_EN
        .ptr     (ptr),
`endif
        .any     (any),
        .winner  (winner)
    );

    // A pulse landing on the grant edge of the same key is a fresh press, not an overrun.
    always_comb begin
        load      = (!out_valid_q || bus.out_ready) && any && !bus.lock;
        grant_vec = '0;
        if (load) grant_vec[winner] = 1'b1;
        ovr_ev    = !bus.lock && (|(bus.key_pulse & pending & ~grant_vec));
        pending_n = bus.lock ? '0 : ((pending & ~grant_vec) | bus.key_pulse);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            pending   <= pending_n;
            overrun_q <= (overrun_q & ~bus.overrun_clr) | ovr_ev;
            if (load) begin
                out_valid_q <= 1'b1;
                out_code_q  <= winner;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef KEY_ARB_RR_EN
    // Pointer moves past the winner only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (winner == CODE_W'(N_KEYS - 1)) ? '0 : winner + CODE_W'(1);
        end
    end
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (|pending) | out_valid_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: expected codes queued at stimulus, checked on handshake.
module tb_key_event_arbiter;
    import detonator_pkg::*;

    localparam int unsigned NK = N_KEYS_DEF;
    localparam int unsigned CW = CODE_W_DEF;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    key_event_arbiter_if #(.N_KEYS(NK), .CODE_W(CW)) bus ();

    key_event_arbiter #(.N_KEYS(NK), .CODE_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NK-1:0] onehot(input int k);
        logic [NK-1:0] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mask(input logic [NK-1:0] m);
        bus.key_pulse = m;
        tick();
        bus.key_pulse = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 60) begin
            tick();
            n++;
        end
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_qlen"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Every accepted code must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_code", 32'(bus.out_code), 32'hdead);
            end else begin
                check_eq("code", 32'(bus.out_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst             = 1'b0;
        bus.key_pulse   = '0;
        bus.lock        = 1'b0;
        bus.out_ready   = 1'b0;
        bus.overrun_clr = 1'b0;
        #12;
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_code", 32'(bus.out_code), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single press: two edges to out_valid, held one cycle
        bus.out_ready = 1'b1;
        exp_q.push_back(5);
        pulse_mask(onehot(5));
        check_eq("t1_lat_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_lat_busy", 32'(bus.busy), 32'd1);
        tick();
        check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_code", 32'(bus.out_code), 32'd5);
        tick();
        check_eq("t1_valid_off", 32'(bus.out_valid), 32'd0);
        check_eq("t1_busy_off", 32'(bus.busy), 32'd0);

        // Simultaneous press
`ifdef KEY_ARB_RR_EN
        exp_q.push_back(7); exp_q.push_back(KEY_CONFIRM); exp_q.push_back(3);
`else
        exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(KEY_CONFIRM);
`endif
        pulse_mask(onehot(3) | onehot(7) | onehot(KEY_CONFIRM));
        tick();
        check_eq("t2_v1", 32'(bus.out_valid), 32'd1);
        tick();
        check_eq("t2_v2", 32'(bus.out_valid), 32'd1);
        tick();
        check_eq("t2_v3", 32'(bus.out_valid), 32'd1);
        drain("t2");

        // Backpressure
        bus.out_ready = 1'b0;
        exp_q.push_back(2);
        pulse_mask(onehot(2));
        repeat (4) tick();
        check_eq("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t3_hold_code", 32'(bus.out_code), 32'd2);
        exp_q.push_back(9);
        pulse_mask(onehot(9));
        repeat (5) tick();
        check_eq("t3_hold_code2", 32'(bus.out_code), 32'd2);
        check_eq("t3_busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b1;
        drain("t3");
        check_eq("t3_overrun", 32'(bus.overrun), 32'd0);

        // Overrun: second key 4 press while the first is still pending
        bus.out_ready = 1'b0;
        exp_q.push_back(8);
        pulse_mask(onehot(8));
        tick();
        exp_q.push_back(4);
        pulse_mask(onehot(4));
        repeat (4) tick();
        check_eq("t4_no_ovr", 32'(bus.overrun), 32'd0);
        pulse_mask(onehot(4));
        check_eq("t4_ovr", 32'(bus.overrun), 32'd1);
        bus.out_ready = 1'b1;
        drain("t4");
        check_eq("t4_sticky", 32'(bus.overrun), 32'd1);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        check_eq("t4_clr", 32'(bus.overrun), 32'd0);

        // Pulse on the grant edge of the same key: new press, no overrun
        bus.out_ready = 1'b0;
        exp_q.push_back(8);
        pulse_mask(onehot(8));
        tick();
        exp_q.push_back(4);
        pulse_mask(onehot(4));
        tick();
        bus.out_ready = 1'b1;
        exp_q.push_back(4);
        pulse_mask(onehot(4));
        check_eq("t4g_no_ovr", 32'(bus.overrun), 32'd0);
        check_eq("t4g_busy", 32'(bus.busy), 32'd1);
        drain("t4g");
        check_eq("t4g_no_ovr_end", 32'(bus.overrun), 32'd0);

        // overrun_clr and an overrun event on the same edge: event wins
        bus.out_ready = 1'b0;
        exp_q.push_back(8);
        pulse_mask(onehot(8));
        tick();
        exp_q.push_back(4);
        pulse_mask(onehot(4));
        bus.overrun_clr = 1'b1;
        pulse_mask(onehot(4));
        bus.overrun_clr = 1'b0;
        check_eq("t4c_ovr_wins", 32'(bus.overrun), 32'd1);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        check_eq("t4c_clr", 32'(bus.overrun), 32'd0);
        bus.out_ready = 1'b1;
        drain("t4c");

        // Lock: loaded code still delivered, pending and new pulses dropped
        bus.out_ready = 1'b0;
        exp_q.push_back(0);
        pulse_mask(onehot(0));
        tick();
        pulse_mask(onehot(1) | onehot(6));
        check_eq("t5_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t5_code", 32'(bus.out_code), 32'd0);
        check_eq("t5_busy", 32'(bus.busy), 32'd1);
        bus.lock      = 1'b1;
        bus.out_ready = 1'b1;
        pulse_mask(onehot(2));
        tick();
        tick();
        bus.lock = 1'b0;
        check_eq("t5_valid_off", 32'(bus.out_valid), 32'd0);
        check_eq("t5_busy_off", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check_eq("t5_no_load", 32'(bus.out_valid), 32'd0);
        check_eq("t5_qlen", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        pulse_mask(onehot(3));
        tick();
        pulse_mask(onehot(5));
        check_eq("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_code", 32'(bus.out_code), 32'd0);
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        check_eq("t6_overrun", 32'(bus.overrun), 32'd0);
        tick();
        tick();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(KEY_CLEAR);
        pulse_mask(onehot(KEY_CLEAR));
        drain("t6");
        check_eq("t6_last_code", 32'(bus.out_code), 32'(KEY_CLEAR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Collects single-cycle press pulses from N_KEYS key_debounce instances, one per keypad key. Each debounce instance emits one pulse after 20 ms of stable press.
- Latches each pulse as a pending request and arbitrates between simultaneous requests.
- Delivers one encoded key code at a time to the password/detonation FSM over a valid/ready handshake.
- Sits between the debounce bank and the code-entry FSM. No press is lost while the FSM is busy.

Parameters:
- N_KEYS, 12, number of keys (0-9, CONFIRM, CLEAR); legal range 2..16
- CODE_W, 4, width of encoded key index; must satisfy 2**CODE_W >= N_KEYS

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- key_pulse  input  N_KEYS  debounced press pulses, one-cycle wide, synchronous to clk
- lock  input  1  from FSM; 1 = discard pending requests and ignore new pulses
- out_ready  input  1  consumer accepts out_code this cycle
- out_valid  output  1  out_code holds an undelivered key
- out_code  output  CODE_W  index of granted key
- busy  output  1  OR of all pending bits and out_valid
- overrun  output  1  sticky; a press merged into an already-pending request
- overrun_clr  input  1  clears overrun

Behaviour:
- Reset, asynchronous: pending=0, out_valid=0, out_code=0, overrun=0, RR pointer=0. All outputs are low during reset.
- Deassertion is used synchronously. First pulse sampling occurs on the first clk edge with rst=1.
- pending[i] is set on the edge that samples key_pulse[i]=1 while lock=0. It is cleared on the edge where key i is granted.
- Load condition: (!out_valid || out_ready) && |pending && !lock.
  - On a load edge, the winner index goes to out_code, out_valid is set to 1, and pending[winner] is cleared.
- Accept with nothing to load: out_valid is set to 0. out_code holds its last value.
- Latency: a pulse sampled at edge E0 gives out_valid=1 after edge E1, when the output stage is free.
- Back-to-back delivery: one key per cycle while out_ready=1.
- out_valid=1 with out_ready=0: out_code and out_valid are stable, and no grant occurs.
- Pulse on key i in the same edge that grants key i: pending[i] stays 1. This is a new press, and overrun is not set.
- Pulse on key i while pending[i]=1 and key i is not granted that edge: pending[i] stays 1 and overrun is set.
- overrun_clr is applied first. A simultaneous overrun event wins, so overrun=1.
- lock=1 clears all pending bits on the next edge, and pulses are ignored.
  - An already-loaded out_valid/out_code is still delivered normally.
  - No new load occurs while lock=1.
- Default arbitration is fixed priority: the lowest index wins.
- busy is combinational from the registers.

Optional Feature:
- Macro: KEY_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at the RR pointer, and the pointer becomes winner+1 after each grant. The pointer wraps from N_KEYS-1 to 0, is not advanced when no grant occurs, and resets to 0.
- Undefined: fixed priority (lowest index), with no pointer register.

Decomposition:
- Shared package/header detonator_pkg holds:
  - N_KEYS and CODE_W defaults
  - key index constants KEY_CONFIRM=10 and KEY_CLEAR=11
- Sub-module key_arb_pick: combinational pending vector (plus RR pointer when enabled) -> any, winner index.
- The top level holds the pending, output, overrun and pointer registers.

Test Plan:
- Single press: key_pulse[5] for 1 cycle, out_ready=1 -> out_valid=1 with out_code=5 two edges after the pulse, for exactly 1 cycle; busy then returns to 0.
- Simultaneous press, fixed priority: pulses on keys 3, 7 and 10 in the same cycle, out_ready=1 -> codes 3, 7, 10 on consecutive cycles. With KEY_ARB_RR_EN and pointer=4, the order is 7, 10, 3.
- Backpressure: out_ready=0 for 10 cycles after the key 2 pulse, then key 9 pulses -> out_code=2 held stable. After out_ready=1, the bench sees 2 and then 9; no overrun.
- Overrun: with out_ready=0, key 4 pulses twice 5 cycles apart -> overrun=1 and a single code 4 delivered. overrun_clr pulse -> overrun=0.
- Lock: keys 1 and 6 pending, out_valid=1 with code 0, lock=1 for 3 cycles -> code 0 delivered on ready, pending cleared, pulses during lock dropped, busy=0 afterwards.
- Reset mid-operation: rst=0 while out_valid=1 and pending nonzero -> all outputs 0 immediately without a clk edge. After release, a key 11 pulse gives out_code=11.
